// File: rtl/bit_population_counter_pkg.sv
// rtl/bit_population_counter_pkg.sv - shared types and latency helper for the stream popcount
package bit_population_counter_pkg;

  typedef enum logic [1:0] {
    PC_ONES,
    PC_ZEROS,
    PC_MASKED,
    PC_HAMMING
  } pc_mode_t;

  // Two fixed stages (mode apply, leaf count) plus one register per group of tree levels.
  function automatic int pc_latency(input int width, input int chunk, input int lvl_per_stg);
    int levels;
    levels = $clog2(width / chunk);
    return 2 + (levels + lvl_per_stg - 1) / lvl_per_stg;
  endfunction

endpackage

// File: rtl/bit_population_counter_leaf.sv
// rtl/bit_population_counter_leaf.sv - combinational population count of one CHUNK-bit slice
module bit_population_counter_leaf
  import bit_population_counter_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]             data,
  output logic [$clog2(CHUNK+1)-1:0]   cnt
);

  localparam int CW = $clog2(CHUNK + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + CW'(data[i]);
    end
  end

endmodule

// File: rtl/bit_population_counter_stream.sv
// rtl/bit_population_counter_stream.sv - pipelined ready/valid popcount with mode, mask and user sideband
module bit_population_counter_stream
  import bit_population_counter_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int CHUNK       = 8,
  parameter int LVL_PER_STG = 1,
  parameter int USER_W      = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [WIDTH-1:0]           mask_i,
  input  logic [1:0]                 mode_i,
  input  logic [USER_W-1:0]          user_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o,
  output logic [USER_W-1:0]          user_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  localparam int NL     = WIDTH / CHUNK;
  localparam int LVLS   = $clog2(NL);
  localparam int LAT    = pc_latency(WIDTH, CHUNK, LVL_PER_STG);
  localparam int NS     = LAT - 2;
  localparam int TREE_N = (NS > 0) ? NS : 1;
  localparam int CW     = $clog2(CHUNK + 1);
  localparam int CNT_W  = $clog2(WIDTH + 1);

  logic                    stall;
  logic                    en;
  logic [LAT-1:0]          valid_q;
  logic [USER_W-1:0]       user_q [LAT];
  logic [WIDTH-1:0]        word_c;
  logic [WIDTH-1:0]        word_q;
  logic [NL-1:0][CW-1:0]   leaf_c;
  logic [NL-1:0][CW-1:0]   leaf_q;
  logic [NL*CNT_W-1:0]     lvl0;
  logic [NL*CNT_W-1:0]     tree_q [TREE_N];

  // One global hold: a stalled output freezes every stage so nothing is dropped or squeezed.
  assign stall   = valid_q[LAT-1] & ~ready_i;
  assign en      = ~stall;
  assign ready_o = ~stall;
  assign valid_o = valid_q[LAT-1];
  assign user_o  = user_q[LAT-1];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q <= {valid_q[LAT-2:0], valid_i};
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int k = 0; k < LAT; k++) begin
        user_q[k] <= '0;
      end
    end else if (en) begin
      user_q[0] <= user_i;
      for (int k = 1; k < LAT; k++) begin
        user_q[k] <= user_q[k-1];
      end
    end
  end

  always_comb begin
    word_c = data_i;
    unique case (pc_mode_t'(mode_i))
      PC_ONES:    word_c = data_i;
      PC_ZEROS:   word_c = ~data_i;
      PC_MASKED:  word_c = data_i & mask_i;
      PC_HAMMING: word_c = data_i ^ mask_i;
      default:    word_c = data_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      word_q <= '0;
    end else if (en) begin
      word_q <= word_c;
    end
  end

  for (genvar k = 0; k < NL; k++) begin : g_leaf
    bit_population_counter_leaf #(
      .CHUNK(CHUNK)
    ) u_leaf (
      .data(word_q[k*CHUNK +: CHUNK]),
      .cnt (leaf_c[k])
    );
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      leaf_q <= '0;
    end else if (en) begin
      leaf_q <= leaf_c;
    end
  end

  // Tree nodes are held at result width; partial sums never exceed WIDTH so nothing overflows.
  always_comb begin
    lvl0 = '0;
    for (int k = 0; k < NL; k++) begin
      lvl0[k*CNT_W +: CNT_W] = CNT_W'(leaf_q[k]);
    end
  end

  // Pairwise-add nlev tree levels in place, starting from n0 live nodes; dead slots read as zero.
  function automatic logic [NL*CNT_W-1:0] reduce_levels(input logic [NL*CNT_W-1:0] v,
                                                        input int n0, input int nlev);
    logic [NL*CNT_W-1:0] r;
    int n;
    r = v;
    n = n0;
    for (int l = 0; l < nlev; l++) begin
      n = n / 2;
      for (int k = 0; k < NL / 2; k++) begin
        if (k < n) begin
          r[k*CNT_W +: CNT_W] = r[2*k*CNT_W +: CNT_W] + r[(2*k+1)*CNT_W +: CNT_W];
        end
      end
    end
    for (int k = 0; k < NL; k++) begin
      if (k >= n) begin
        r[k*CNT_W +: CNT_W] = '0;
      end
    end
    return r;
  endfunction

  for (genvar s = 0; s < NS; s++) begin : g_stage
    localparam int DONE = s * LVL_PER_STG;
    localparam int NLEV = ((LVLS - DONE) < LVL_PER_STG) ? (LVLS - DONE) : LVL_PER_STG;
    localparam int NIN  = NL >> DONE;

    logic [NL*CNT_W-1:0] stage_in;

    if (s == 0) begin : g_first
      assign stage_in = lvl0;
    end else begin : g_next
      assign stage_in = tree_q[s-1];
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        tree_q[s] <= '0;
      end else if (en) begin
        tree_q[s] <= reduce_levels(stage_in, NIN, NLEV);
      end
    end
  end

  if (NS == 0) begin : g_out_leaf
    assign cnt_o = lvl0[CNT_W-1:0];
  end else begin : g_out_tree
    assign cnt_o = tree_q[NS-1][CNT_W-1:0];
  end

endmodule

// File: tb/tb_bit_population_counter_stream.sv
// tb/tb_bit_population_counter_stream.sv - scoreboard bench for the stream popcount
module tb_bit_population_counter_stream;

  typedef struct {
    int cnt;
    int user;
    int cyc;
    bit lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        sw_rst_n;
  logic [63:0] d_in;
  logic [63:0] m_in;
  logic [1:0]  mode_in;
  logic [3:0]  user_in;
  logic        vin;
  logic        rdy_out;
  logic [6:0]  cnt_out;
  logic [3:0]  user_out;
  logic        vout;
  logic        rdy_in;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   bp = 1'b0;
  bit   lat_chk = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_population_counter_stream #(
    .WIDTH(64), .CHUNK(8), .LVL_PER_STG(1), .USER_W(4)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(d_in), .mask_i(m_in), .mode_i(mode_in),
    .user_i(user_in), .valid_i(vin), .ready_o(rdy_out), .cnt_o(cnt_out),
    .user_o(user_out), .valid_o(vout), .ready_i(rdy_in)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected expected clean completion", name);
  endtask

  // Reference: count the ones of the selected word, restricted to the low w bits.
  function automatic int ref_cnt(input logic [127:0] d, input logic [127:0] m,
                                 input logic [1:0] mo, input int w);
    logic [127:0] x;
    logic [127:0] lim;
    lim = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    case (mo)
      2'd0:    x = d;
      2'd1:    x = ~d;
      2'd2:    x = d & m;
      default: x = d ^ m;
    endcase
    return $countones(x & lim);
  endfunction

  always @(negedge clk) begin
    if (arst_n) begin
      chk("ready_rule", rdy_out, !(vout && !rdy_in));
      if (vin && rdy_out)
        sb.push_back('{ref_cnt(128'(d_in), 128'(m_in), mode_in, 64), int'(user_in), cyc, lat_chk});
      if (vout && rdy_in) begin
        if (sb.size() == 0) begin
          fail_msg("unexpected_output");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("cnt", cnt_out, e.cnt);
          chk("user", user_out, e.user);
          if (e.lat) chk("latency", cyc - e.cyc, 5);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      if (bp) rdy_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] m,
                      input logic [1:0] mo, input logic [3:0] u);
    int t;
    bit acc;
    d_in = d; m_in = m; mode_in = mo; user_in = u; vin = 1'b1;
    t = 0;
    acc = 1'b0;
    do begin
      if (bp) rdy_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = rdy_out;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 100);
    if (!acc) fail_msg("send_timeout");
    vin = 1'b0;
  endtask

  task automatic drain();
    int t;
    bp = 1'b0;
    rdy_in = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) fail_msg("drain");
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W    = (g == 0) ? 8 : (g == 1) ? 32 : 128;
    localparam int C    = (g == 0) ? 8 : (g == 1) ? 4 : 16;
    localparam int P    = (g == 0) ? 1 : (g == 1) ? 2 : 3;
    localparam int LATX = (g == 0) ? 2 : (g == 1) ? 4 : 3;
    localparam int OW   = $clog2(W + 1);

    logic [W-1:0]  d;
    logic [W-1:0]  m;
    logic [1:0]    mo;
    logic [3:0]    u;
    logic          v;
    logic          r_o;
    logic [OW-1:0] c_o;
    logic [3:0]    u_o;
    logic          v_o;
    exp_t          q[$];
    int            n_acc = 0;
    bit            done = 1'b0;

    bit_population_counter_stream #(
      .WIDTH(W), .CHUNK(C), .LVL_PER_STG(P), .USER_W(4)
    ) u_sw (
      .clk_i(clk), .arst_n_i(sw_rst_n), .data_i(d), .mask_i(m), .mode_i(mo),
      .user_i(u), .valid_i(v), .ready_o(r_o), .cnt_o(c_o),
      .user_o(u_o), .valid_o(v_o), .ready_i(1'b1)
    );

    always @(negedge clk) begin
      if (sw_rst_n) begin
        if (v && r_o) begin
          q.push_back('{ref_cnt(128'(d), 128'(m), mo, W), int'(u), cyc, 1'b1});
          n_acc++;
        end
        if (v_o) begin
          if (q.size() == 0) begin
            fail_msg($sformatf("sweep%0d_unexpected", g));
          end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("sweep%0d_cnt", g), c_o, e.cnt);
            chk($sformatf("sweep%0d_user", g), u_o, e.user);
            chk($sformatf("sweep%0d_latency", g), cyc - e.cyc, LATX);
          end
        end
      end
    end

    initial begin
      logic [127:0] r;
      int t;
      d = '0; m = '0; mo = 2'd0; u = 4'd0; v = 1'b0;
      wait (sw_rst_n === 1'b1);
      @(posedge clk);
      #1;
      t = 0;
      while (n_acc < 1000 && t < 5000) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        d = r[W-1:0];
        r = {$urandom, $urandom, $urandom, $urandom};
        m = r[W-1:0];
        mo = 2'($urandom_range(0, 3));
        u = 4'($urandom_range(0, 15));
        v = ($urandom_range(0, 4) != 0);
        @(posedge clk);
        #1;
        t++;
      end
      v = 1'b0;
      if (n_acc < 1000) fail_msg($sformatf("sweep%0d_stimulus", g));
      t = 0;
      while (q.size() != 0 && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (q.size() != 0) fail_msg($sformatf("sweep%0d_drain", g));
      done = 1'b1;
    end
  end

  initial begin
    logic [63:0] da;
    logic [63:0] ma;
    int t;
    arst_n = 1'b0; sw_rst_n = 1'b0;
    d_in = {$urandom, $urandom}; m_in = {$urandom, $urandom};
    mode_in = 2'd0; user_in = 4'hA; vin = 1'b1; rdy_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_o", vout, 0);
    chk("reset_cnt_o", cnt_out, 0);
    chk("reset_user_o", user_out, 0);
    chk("reset_ready_o", rdy_out, 1);
    vin = 1'b0;
    #2;
    arst_n = 1'b1; sw_rst_n = 1'b1;
    idle(8);

    lat_chk = 1'b1;
    da = 64'h00FF_0000_0000_000F;
    ma = 64'hFFFF_FFFF_0000_0000;
    for (int mo = 0; mo < 4; mo++) begin
      send(da, ma, 2'(mo), 4'(mo));
      idle(6);
    end
    send(64'h0, ma, 2'd0, 4'd4);
    send({64{1'b1}}, ma, 2'd0, 4'd5);
    send({64{1'b1}}, ma, 2'd1, 4'd6);
    drain();
    lat_chk = 1'b0;

    bp = 1'b1;
    for (int i = 0; i < 20; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 4'(i));
    idle(10);
    drain();

    bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    for (int i = 0; i < 3; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 2'd0, 4'(i));
    #2;
    arst_n = 1'b0;
    #1;
    chk("midreset_valid_o", vout, 0);
    chk("midreset_cnt_o", cnt_out, 0);
    chk("midreset_ready_o", rdy_out, 1);
    chk("midreset_in_flight", sb.size(), 3);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    idle(12);
    drain();

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) fail_msg("sweep_wait");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
